// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D round-robin scheduler: channel numbers,
// FSM state encodings and the SPI command-word builder.
package a2d_pkg;

    // A2D mux channels wired to each sensor
    localparam logic [2:0] A2D_CH_BATT   = 3'd0;
    localparam logic [2:0] A2D_CH_CURR   = 3'd1;
    localparam logic [2:0] A2D_CH_BRAKE  = 3'd3;
    localparam logic [2:0] A2D_CH_TORQUE = 3'd4;

    // Scheduler FSM state encodings
    typedef logic [2:0] a2d_state_t;
    localparam a2d_state_t ST_IDLE     = 3'd0;
    localparam a2d_state_t ST_CNV      = 3'd1;
    localparam a2d_state_t ST_WAIT_CNV = 3'd2;
    localparam a2d_state_t ST_GAP      = 3'd3;
    localparam a2d_state_t ST_RD       = 3'd4;
    localparam a2d_state_t ST_WAIT_RD  = 3'd5;
    localparam a2d_state_t ST_STORE    = 3'd6;

    // SPI command word selecting an A2D channel
    function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_sched.sv
// Round-robin scheduler sharing one SPI A2D converter among four sensors.
// Each conversion is a convert transaction, a one-clock settle gap, then a
// read transaction whose low 12 bits land in the selected sample register.
module a2d_sched
    import a2d_pkg::*;
#(
    parameter bit         FAST_SIM  = 1'b0,
    parameter logic [2:0] CH_BATT   = A2D_CH_BATT,
    parameter logic [2:0] CH_CURR   = A2D_CH_CURR,
    parameter logic [2:0] CH_BRAKE  = A2D_CH_BRAKE,
    parameter logic [2:0] CH_TORQUE = A2D_CH_TORQUE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic [3:0]  smpl_vld
);

    logic [13:0] cnt;
    logic        tick;
    a2d_state_t  state;
    logic [1:0]  rr_ptr;
    logic [2:0]  ch_sel;
    logic [11:0] sample;
    logic        unused_hi;

    // The upper nibble of the read word carries no sample data
    assign unused_hi = ^rd_data[15:12];

    // Round-start tick when the active counter bits are all ones
    assign tick = FAST_SIM ? (&cnt[9:0]) : (&cnt);

    // Map the round-robin pointer onto the A2D channel number
    always_comb begin
        ch_sel = CH_BATT;
        case (rr_ptr)
            2'd0:    ch_sel = CH_BATT;
            2'd1:    ch_sel = CH_CURR;
            2'd2:    ch_sel = CH_BRAKE;
            2'd3:    ch_sel = CH_TORQUE;
            default: ch_sel = CH_BATT;
        endcase
    end

    // Free-running round interval counter, wrapping to zero after the tick
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 14'd0;
        end else if (tick) begin
            cnt <= 14'd0;
        end else begin
            cnt <= cnt + 14'd1;
        end
    end

    // Conversion sequencer: issues both SPI transactions and captures the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            wrt    <= 1'b0;
            cmd    <= 16'h0000;
            sample <= 12'h000;
        end else begin
            wrt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Ticks seen in any other state are simply dropped
                    if (tick) begin
                        state <= ST_CNV;
                        wrt   <= 1'b1;
                        cmd   <= mk_cmd(ch_sel);
                    end
                end
                ST_CNV:      state <= ST_WAIT_CNV;
                ST_WAIT_CNV: if (spi_done) state <= ST_GAP;
                ST_GAP: begin
                    // Read transaction resends the same word; its echo is ignored
                    state <= ST_RD;
                    wrt   <= 1'b1;
                    cmd   <= mk_cmd(ch_sel);
                end
                ST_RD:       state <= ST_WAIT_RD;
                ST_WAIT_RD: begin
                    if (spi_done) begin
                        sample <= rd_data[11:0];
                        state  <= ST_STORE;
                    end
                end
                ST_STORE:    state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Result registers, valid strobes and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            batt     <= 12'h000;
            curr     <= 12'h000;
            brake    <= 12'h000;
            torque   <= 12'h000;
            smpl_vld <= 4'b0000;
            rr_ptr   <= 2'd0;
        end else begin
            smpl_vld <= 4'b0000;
            if (state == ST_STORE) begin
                case (rr_ptr)
                    2'd0:    batt   <= sample;
                    2'd1:    curr   <= sample;
                    2'd2:    brake  <= sample;
                    2'd3:    torque <= sample;
                    default: batt   <= sample;
                endcase
                smpl_vld <= 4'b0001 << rr_ptr;
                rr_ptr   <= rr_ptr + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_a2d_sched.sv
// Directed bench for a2d_sched with a behavioural SPI_mnrch responder.
`timescale 1ns/1ps
module tb_a2d_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [11:0] batt, curr, brake, torque;
    logic [3:0]  smpl_vld;

    logic        model_done, spur_done;
    logic [15:0] model_rd;
    logic [15:0] rd_val;
    int          spi_lat;
    int          wrt_cnt, vld_cnt;
    logic        wrt_prev, dbl_wrt;
    int          n_chk, n_pass;
    int          cyc, c1, c2, v0, w0;
    logic        seen;

    assign spi_done = model_done | spur_done;
    assign rd_data  = spur_done ? 16'hFFFF : model_rd;

    a2d_sched #(.FAST_SIM(1'b1)) dut (
        .clk(clk), .rst(rst), .spi_done(spi_done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .batt(batt), .curr(curr), .brake(brake),
        .torque(torque), .smpl_vld(smpl_vld)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    endtask

    // Count edges until wrt is seen (sampled #1 after the edge)
    task automatic wait_wrt(output int cycles, output logic found);
        cycles = 0;
        found  = 1'b0;
        while (!found && cycles < 4000) begin
            @(posedge clk); #1;
            cycles++;
            found = wrt;
        end
    endtask

    task automatic wait_vld(output int cycles, output logic found);
        cycles = 0;
        found  = 1'b0;
        while (!found && cycles < 4000) begin
            @(posedge clk); #1;
            cycles++;
            found = (smpl_vld != 4'b0000);
        end
    endtask

    // SPI responder: done pulse spi_lat clocks after each wrt
    initial begin
        model_done = 1'b0;
        model_rd   = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (wrt) begin
                repeat (spi_lat) @(posedge clk);
                #1;
                model_rd   = rd_val;
                model_done = 1'b1;
                @(posedge clk); #1;
                model_done = 1'b0;
            end
        end
    end

    // Pulse counters and back-to-back wrt detector, sampled on the falling edge
    initial begin
        wrt_cnt = 0; vld_cnt = 0; wrt_prev = 1'b0; dbl_wrt = 1'b0;
        forever begin
            @(negedge clk);
            if (wrt) wrt_cnt++;
            if (wrt && wrt_prev) dbl_wrt = 1'b1;
            wrt_prev = wrt;
            if (smpl_vld != 4'b0000) vld_cnt++;
        end
    end

    // One ordinary conversion: check cmd at wrt, then strobe and register
    task automatic convert(input string tag, input logic [15:0] data,
                           input logic [15:0] exp_cmd, input logic [3:0] exp_vld);
        rd_val = data;
        wait_wrt(cyc, seen);
        check_eq({tag, "_wrt_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_cmd"}, 32'(cmd), 32'(exp_cmd));
        wait_vld(cyc, seen);
        check_eq({tag, "_vld"}, 32'(smpl_vld), 32'(exp_vld));
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; spur_done = 1'b0; rd_val = 16'h0000; spi_lat = 3;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wrt", 32'(wrt), 32'd0);
        check_eq("rst_cmd", 32'(cmd), 32'h0000);
        check_eq("rst_batt", 32'(batt), 32'h000);
        check_eq("rst_vld", 32'(smpl_vld), 32'h0);
        rst = 1'b0;

        // First tick after 1024 edges, battery conversion
        rd_val = 16'h05A5;
        wait_wrt(cyc, seen);
        check_eq("t1_first_wrt_cycle", 32'(cyc), 32'd1024);
        check_eq("t1_cmd", 32'(cmd), 32'h0000);
        wait_vld(cyc, seen);
        check_eq("t1_vld", 32'(smpl_vld), 32'h1);
        check_eq("t1_batt", 32'(batt), 32'h5A5);

        // Round-robin through the remaining channels and wrap to batt
        convert("t2_curr", 16'h0111, 16'h0800, 4'b0010);
        check_eq("t2_curr_val", 32'(curr), 32'h111);
        convert("t2_brake", 16'h0222, 16'h1800, 4'b0100);
        check_eq("t2_brake_val", 32'(brake), 32'h222);
        convert("t2_torque", 16'hF123, 16'h2000, 4'b1000);
        check_eq("t6_torque_val", 32'(torque), 32'h123);
        check_eq("t6_batt_hold", 32'(batt), 32'h5A5);
        check_eq("t6_curr_hold", 32'(curr), 32'h111);
        check_eq("t6_brake_hold", 32'(brake), 32'h222);
        convert("t2_wrap", 16'h0ABC, 16'h0000, 4'b0001);
        check_eq("t2_wrap_batt", 32'(batt), 32'hABC);

        // Spurious done while IDLE
        @(posedge clk); #1;
        v0 = vld_cnt;
        spur_done = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("t5_idle_no_vld", 32'(vld_cnt), 32'(v0));
        check_eq("t5_idle_batt", 32'(batt), 32'hABC);
        check_eq("t5_idle_curr", 32'(curr), 32'h111);

        // Spurious done during GAP on the next (curr) conversion
        rd_val = 16'h0333;
        wait_wrt(cyc, seen);
        check_eq("t5_gap_cmd", 32'(cmd), 32'h0800);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #2;
            cyc++;
            seen = model_done;
        end
        check_eq("t5_gap_done_seen", 32'(seen), 32'd1);
        @(posedge clk); #2;
        spur_done = 1'b1;
        @(posedge clk); #2;
        spur_done = 1'b0;
        wait_vld(cyc, seen);
        check_eq("t5_gap_vld", 32'(smpl_vld), 32'h2);
        check_eq("t5_gap_curr", 32'(curr), 32'h333);
        @(posedge clk); #1;
        check_eq("t5_gap_one_vld", 32'(vld_cnt), 32'(v0 + 1));

        // Stretched SPI: intervening ticks dropped, no extra wrt, no skipped channel
        w0 = wrt_cnt;
        spi_lat = 1100;
        rd_val = 16'h0444;
        wait_wrt(cyc, seen);
        check_eq("t3_cmd", 32'(cmd), 32'h1800);
        wait_vld(c1, seen);
        check_eq("t3_vld", 32'(smpl_vld), 32'h4);
        check_eq("t3_brake", 32'(brake), 32'h444);
        spi_lat = 3;
        @(posedge clk); #1;
        check_eq("t3_two_wrt", 32'(wrt_cnt - w0), 32'd2);
        wait_wrt(c2, seen);
        check_eq("t3_next_gap", 32'(c1 + 1 + c2), 32'd3072);
        check_eq("t3_next_cmd", 32'(cmd), 32'h2000);
        wait_vld(cyc, seen);
        check_eq("t3_torque", 32'(torque), 32'h444);

        convert("t4_pre_batt", 16'h0666, 16'h0000, 4'b0001);
        check_eq("t4_pre_batt_val", 32'(batt), 32'h666);

        // Reset during WAIT_RD of a curr conversion
        spi_lat = 20;
        rd_val = 16'h0555;
        wait_wrt(cyc, seen);
        wait_wrt(cyc, seen);
        check_eq("t4_rd_wrt_seen", 32'(seen), 32'd1);
        check_eq("t4_rd_cmd", 32'(cmd), 32'h0800);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("t4_rst_wrt", 32'(wrt), 32'd0);
        check_eq("t4_rst_cmd", 32'(cmd), 32'h0000);
        check_eq("t4_rst_regs", 32'({batt, curr} | {brake, torque}), 32'h0);
        check_eq("t4_rst_vld", 32'(smpl_vld), 32'h0);
        v0 = vld_cnt;
        rd_val = 16'h0789;
        wait_wrt(cyc, seen);
        check_eq("t4_restart_cycle", 32'(cyc), 32'd1024);
        check_eq("t4_restart_cmd", 32'(cmd), 32'h0000);
        check_eq("t4_late_done_ignored", 32'(vld_cnt), 32'(v0));
        wait_vld(cyc, seen);
        check_eq("t4_vld", 32'(smpl_vld), 32'h1);
        check_eq("t4_batt", 32'(batt), 32'h789);
        check_eq("t4_curr_cleared", 32'(curr), 32'h000);

        check_eq("no_back_to_back_wrt", 32'(dbl_wrt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
